// File: rtl/servo_pos_sequencer.sv
// servo_pos_sequencer
//   Generates the l_ctrl/r_ctrl commands for a three-position servo PWM
//   driver running on the same 10 kHz clock. It debounces the two buttons
//   and chooses between manual button control and an automatic
//   C->R->C->L sweep. After every position change it holds the position for
//   a minimum dwell time so the servo can settle.
//
// Ports
//   clk        10 kHz clock
//   rst        asynchronous active-high reset
//   btn_l/r    raw buttons (asynchronous, active-high)
//   auto_en    enables the automatic sweep (synchronous level)
//   l_ctrl     1 selects 0 deg   (pos == LEFT)
//   r_ctrl     1 selects 180 deg (pos == RIGHT)
//   pos        commanded position: 0 LEFT, 1 CENTER, 2 RIGHT
//   busy       dwell in progress; position changes are blocked
//   auto_mode  registered copy of the AUTO mode condition
module servo_pos_sequencer #(
   parameter int FRAME_TICKS  = 200,
   parameter int DWELL_FRAMES = 25,
   parameter int AUTO_FRAMES  = 50,
   parameter int DEB_TICKS    = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_l,
   input  logic       btn_r,
   input  logic       auto_en,
   output logic       l_ctrl,
   output logic       r_ctrl,
   output logic [1:0] pos,
   output logic       busy,
   output logic       auto_mode
);

   localparam logic [1:0]  P_LEFT     = 2'd0;
   localparam logic [1:0]  P_CENTER   = 2'd1;
   localparam logic [1:0]  P_RIGHT    = 2'd2;
   localparam logic [23:0] DWELL_LAST = 24'(DWELL_FRAMES * FRAME_TICKS - 1);
   localparam logic [23:0] AUTO_LAST  = 24'(AUTO_FRAMES * FRAME_TICKS - 1);
   localparam logic [15:0] DEB_N      = 16'(DEB_TICKS);

   // ---------------- debounce: bit 0 = left, bit 1 = right ----------------
   logic [1:0]       btn_raw;
   logic [1:0]       sync1_q, sync2_q, db_q;
   logic [1:0][15:0] deb_cnt_q;

   assign btn_raw = {btn_r, btn_l};

   // A run of disagreement is counted after the synchronizer. The counter
   // must reach DEB_N before the new level is accepted. This gives a db_x
   // change at clock 2+DEB_TICKS for a raw edge that arrives before clock 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         deb_cnt_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == DEB_N) begin
               db_q[i]      <= sync2_q[i];
               deb_cnt_q[i] <= '0;
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + 16'd1;
            end
         end
      end
   end

   // ---------------- mode and target selection ----------------
   logic [1:0]  pos_q, pos_d;
   logic        l_ctrl_q, r_ctrl_q, busy_q, dir_q, auto_mode_q;
   logic [23:0] dwell_q, tmr_q;
   logic        auto_c, step;

   assign auto_c = auto_en & ~db_q[0] & ~db_q[1];

   always_comb begin
      pos_d = pos_q;
      if (auto_c) begin
         if (tmr_q == AUTO_LAST)
            pos_d = (pos_q == P_CENTER) ? (dir_q ? P_RIGHT : P_LEFT) : P_CENTER;
      end else begin
         case (db_q)
            2'b01:   pos_d = P_LEFT;
            2'b10:   pos_d = P_RIGHT;
            2'b00:   pos_d = P_CENTER;
            default: pos_d = pos_q;        // both pressed: hold
         endcase
      end
   end

   // Requests made during a dwell are not queued. Whatever target is
   // present on the first non-busy clock is the one that gets applied.
   assign step = ~busy_q & (pos_d != pos_q);

   // ---------------- position, dwell, auto timer ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_q       <= P_CENTER;
         l_ctrl_q    <= 1'b0;
         r_ctrl_q    <= 1'b0;
         busy_q      <= 1'b0;
         dwell_q     <= '0;
         tmr_q       <= '0;
         dir_q       <= 1'b1;
         auto_mode_q <= 1'b0;
      end else begin
         auto_mode_q <= auto_c;
         if (step) begin
            pos_q    <= pos_d;
            l_ctrl_q <= (pos_d == P_LEFT);
            r_ctrl_q <= (pos_d == P_RIGHT);
            busy_q   <= 1'b1;
            dwell_q  <= '0;
            // Leaving an outer position flips the sweep direction. This
            // also happens on manual moves, so a later sweep continues
            // away from the side it last left.
            if (pos_q != P_CENTER)
               dir_q <= ~dir_q;
         end else if (busy_q) begin
            if (dwell_q == DWELL_LAST)
               busy_q <= 1'b0;
            else
               dwell_q <= dwell_q + 24'd1;
         end
         // The timer is held at 0 in MANUAL mode, so entering AUTO starts a
         // fresh period. The timer saturates at the last count, which makes
         // the step wait until the dwell has finished.
         if (!auto_c || step)
            tmr_q <= '0;
         else if (tmr_q != AUTO_LAST)
            tmr_q <= tmr_q + 24'd1;
      end
   end

   assign pos       = pos_q;
   assign l_ctrl    = l_ctrl_q;
   assign r_ctrl    = r_ctrl_q;
   assign busy      = busy_q;
   assign auto_mode = auto_mode_q;

endmodule

// File: tb/tb_servo_pos_sequencer.sv
module tb_servo_pos_sequencer;

   localparam int FT = 4, DF = 2, AF = 3, DT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_l = 1'b0, btn_r = 1'b0, auto_en = 1'b0;
   logic       l_ctrl, r_ctrl, busy, auto_mode;
   logic [1:0] pos;

   servo_pos_sequencer #(
      .FRAME_TICKS(FT), .DWELL_FRAMES(DF), .AUTO_FRAMES(AF), .DEB_TICKS(DT)
   ) dut (
      .clk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r), .auto_en(auto_en),
      .l_ctrl(l_ctrl), .r_ctrl(r_ctrl), .pos(pos), .busy(busy),
      .auto_mode(auto_mode)
   );

   always #5 clk = ~clk;

   // One record either drives the inputs before edge t or states the
   // outputs expected just after edge t.
   typedef struct {
      int         t;
      logic       drv;
      logic       bl, br, ae;
      logic       chk;
      logic [1:0] pos;
      logic       busy;
      logic       am;
   } vec_t;

   typedef struct {
      int         t;
      logic [1:0] pos;
      logic       busy;
      logic       am;
   } exp_t;

   vec_t  vecs[$];
   exp_t  sb[$];
   int    n_vec = 0;
   int    n_bad = 0;
   string scen;

   function automatic void put_drv(int t, logic bl, logic br, logic ae);
      vecs.push_back('{t, 1'b1, bl, br, ae, 1'b0, 2'd0, 1'b0, 1'b0});
   endfunction

   function automatic void put_exp(int t, logic [1:0] p, logic b, logic am);
      vecs.push_back('{t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, p, b, am});
   endfunction

   function automatic void put_range(int t0, int t1, logic [1:0] p, logic b, logic am);
      for (int t = t0; t <= t1; t++) put_exp(t, p, b, am);
   endfunction

   // Uninterrupted sweep from reset: steps at clocks 11, 23, 35, ...
   // following C->R->C->L->C->R. The dwell lasts 8 clocks after each step.
   function automatic void gen_auto(int tend);
      logic [1:0] p = 2'd1;
      logic       d = 1'b1;
      int         last = -100;
      for (int t = 0; t <= tend; t++) begin
         if (t >= 11 && (t - 11) % 12 == 0) begin
            if (p == 2'd1) p = d ? 2'd2 : 2'd0;
            else begin p = 2'd1; d = ~d; end
            last = t;
         end
         put_exp(t, p, (t - last) < 8, 1'b1);
      end
   endfunction

   task automatic check(input exp_t e);
      logic [5:0] act, req;
      act = {pos, busy, auto_mode, l_ctrl, r_ctrl};
      req = {e.pos, e.busy, e.am, e.pos == 2'd0, e.pos == 2'd2};
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s t=%0d got pos=%0d busy=%b auto=%b l=%b r=%b, want pos=%0d busy=%b auto=%b l=%b r=%b",
                  scen, e.t, pos, busy, auto_mode, l_ctrl, r_ctrl,
                  e.pos, e.busy, e.am, req[1], req[0]);
      end
   endtask

   task automatic run_vecs(input int tend);
      exp_t e;
      for (int t = 0; t <= tend; t++) begin
         foreach (vecs[i]) if (vecs[i].t == t && vecs[i].drv) begin
            btn_l = vecs[i].bl; btn_r = vecs[i].br; auto_en = vecs[i].ae;
         end
         foreach (vecs[i]) if (vecs[i].t == t && vecs[i].chk)
            sb.push_back('{t, vecs[i].pos, vecs[i].busy, vecs[i].am});
         @(posedge clk); #1;
         while (sb.size() > 0 && sb[0].t == t) begin
            e = sb.pop_front();
            check(e);
         end
      end
      vecs.delete();
   endtask

   task automatic do_reset();
      btn_l = 1'b0; btn_r = 1'b0; auto_en = 1'b0; rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // reset state, checked while reset is still asserted
      scen = "reset";
      repeat (2) @(posedge clk);
      #1 check('{0, 2'd1, 1'b0, 1'b0});

      // idle for 50 clocks, with a 2-clock btn_l glitch that must be ignored
      scen = "idle";
      do_reset();
      put_drv(0, 0, 0, 0);
      put_drv(20, 1, 0, 0); put_drv(22, 0, 0, 0);
      put_range(0, 49, 2'd1, 1'b0, 1'b0);
      run_vecs(49);

      // left press: pos=0 at clock 6, busy 6..13; btn_r glitch ignored
      scen = "left_press";
      do_reset();
      put_drv(0, 1, 0, 0); put_drv(8, 1, 1, 0); put_drv(10, 1, 0, 0);
      put_range(0, 5, 2'd1, 1'b0, 1'b0);
      put_range(6, 13, 2'd0, 1'b1, 1'b0);
      put_range(14, 20, 2'd0, 1'b0, 1'b0);
      run_vecs(20);

      // right requested during dwell: goes 0 -> 2 with no stop at center
      scen = "latest_wins";
      do_reset();
      put_drv(0, 1, 0, 0); put_drv(8, 0, 0, 0); put_drv(9, 0, 1, 0);
      put_range(0, 5, 2'd1, 1'b0, 1'b0);
      put_range(6, 13, 2'd0, 1'b1, 1'b0);
      put_exp(14, 2'd0, 1'b0, 1'b0);
      put_range(15, 22, 2'd2, 1'b1, 1'b0);
      put_range(23, 26, 2'd2, 1'b0, 1'b0);
      run_vecs(26);

      // automatic sweep 1->2->1->0->1->2 every 12 clocks
      scen = "auto_sweep";
      do_reset();
      put_drv(0, 0, 0, 1);
      gen_auto(62);
      run_vecs(62);

      // manual override from RIGHT, then resume the sweep after release
      scen = "auto_override";
      do_reset();
      put_drv(0, 0, 0, 1); put_drv(16, 1, 0, 1); put_drv(30, 0, 0, 1);
      put_range(0, 10, 2'd1, 1'b0, 1'b1);
      put_range(11, 18, 2'd2, 1'b1, 1'b1);
      put_range(19, 21, 2'd2, 1'b0, 1'b1);
      put_range(22, 29, 2'd0, 1'b1, 1'b0);
      put_range(30, 35, 2'd0, 1'b0, 1'b0);
      put_range(36, 46, 2'd0, 1'b0, 1'b1);
      put_range(47, 54, 2'd1, 1'b1, 1'b1);
      put_range(55, 58, 2'd1, 1'b0, 1'b1);
      put_range(59, 62, 2'd2, 1'b1, 1'b1);
      run_vecs(62);

      // both buttons debounce on the same clock: hold at center
      scen = "both_same_clock";
      do_reset();
      put_drv(0, 1, 1, 0);
      put_range(0, 15, 2'd1, 1'b0, 1'b0);
      run_vecs(15);

      // both pressed while at RIGHT: hold at 2
      scen = "both_hold";
      do_reset();
      put_drv(0, 0, 1, 0); put_drv(16, 1, 1, 0);
      put_range(0, 5, 2'd1, 1'b0, 1'b0);
      put_range(6, 13, 2'd2, 1'b1, 1'b0);
      put_range(14, 30, 2'd2, 1'b0, 1'b0);
      run_vecs(30);

      // asynchronous reset mid-dwell with dir=0; after reset the sweep
      // must head RIGHT first, which shows that dir was restored to 1
      scen = "async_reset";
      do_reset();
      put_drv(0, 0, 0, 1);
      gen_auto(25);
      run_vecs(25);
      #2 rst = 1'b1;
      #1 check('{26, 2'd1, 1'b0, 1'b0});
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      scen = "after_reset_sweep";
      put_drv(0, 0, 0, 1);
      gen_auto(14);
      run_vecs(14);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
